// File: rtl/timer0_count_unit.sv
// rtl/timer0_count_unit.sv - ATMega32A Timer/Counter0 count, compare and OC0 waveform core
// Optional force-output-compare input (foc) is enabled by defining TIMER0_FOC_EN.
module timer0_count_unit #(
   parameter int WIDTH    = 8,
   parameter bit OC0_INIT = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick,
   input  logic [1:0]       wgm,
   input  logic [1:0]       com,
   input  logic             tcnt_wr,
   input  logic [WIDTH-1:0] tcnt_din,
   input  logic             ocr_wr,
   input  logic [WIDTH-1:0] ocr_din,
   input  logic             tov_clr,
   input  logic             ocf_clr,
`ifdef TIMER0_FOC_EN
   input  logic             foc,
`endif
   output logic [WIDTH-1:0] tcnt,
   output logic [WIDTH-1:0] ocr,
   output logic             tov,
   output logic             ocf,
   output logic             oc0
);
   typedef enum logic [1:0] {
      MODE_NORMAL = 2'b00,
      MODE_PCPWM  = 2'b01,
      MODE_CTC    = 2'b10,
      MODE_FAST   = 2'b11
   } mode_t;

   localparam logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] ZERO = '0;
   localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

   mode_t            mode;
   logic [WIDTH-1:0] ocr_act;
   logic [WIDTH-1:0] ocr_act_nxt;
   logic [WIDTH-1:0] tcnt_nxt;
   logic             dir;
   logic             dir_nxt;
   logic             skip;
   logic             oc_reg;
   logic             oc_nxt;
   logic             step;
   logic             match;
   logic             tov_set;
   logic             nonpwm;
   logic             force_cmp;
   logic             connected;

   assign mode   = mode_t'(wgm);
   assign nonpwm = (mode == MODE_NORMAL) || (mode == MODE_CTC);

`ifdef TIMER0_FOC_EN
   assign force_cmp = foc & nonpwm;
`else
   assign force_cmp = 1'b0;
`endif

   // A TCNT0 write consumes the tick; the following tick may not raise a compare match.
   assign step      = tick & ~tcnt_wr;
   assign match     = step & ~skip & (tcnt == ocr_act);
   assign connected = com[1] | (com[0] & nonpwm);
   assign oc0       = oc_reg & connected;

   always_comb begin
      tcnt_nxt    = tcnt;
      dir_nxt     = (mode == MODE_PCPWM) ? dir : 1'b0;
      ocr_act_nxt = ocr_act;
      oc_nxt      = oc_reg;
      tov_set     = 1'b0;

      if (tcnt_wr) begin
         tcnt_nxt = tcnt_din;
      end else if (step) begin
         case (mode)
            MODE_NORMAL: begin
               tcnt_nxt = tcnt + ONE;
               tov_set  = (tcnt == MAX);
            end
            MODE_CTC: begin
               tcnt_nxt = match ? ZERO : tcnt + ONE;
               tov_set  = (tcnt == MAX);
            end
            MODE_FAST: begin
               tcnt_nxt = tcnt + ONE;
               tov_set  = (tcnt == MAX);
               if (tcnt == MAX) ocr_act_nxt = ocr;
            end
            MODE_PCPWM: begin
               // dir flips on the edge that reaches either end, so TOP counts as down, BOTTOM as up
               tcnt_nxt = dir ? tcnt - ONE : tcnt + ONE;
               if (tcnt_nxt == MAX) begin
                  dir_nxt     = 1'b1;
                  ocr_act_nxt = ocr;
               end else if (tcnt_nxt == ZERO) begin
                  dir_nxt = 1'b0;
                  tov_set = dir;
               end
            end
            default: tcnt_nxt = tcnt;
         endcase
      end

      if (ocr_wr && nonpwm) ocr_act_nxt = ocr_din;

      if (nonpwm) begin
         if (match || force_cmp) begin
            case (com)
               2'b01:   oc_nxt = ~oc_reg;
               2'b10:   oc_nxt = 1'b0;
               2'b11:   oc_nxt = 1'b1;
               default: oc_nxt = oc_reg;
            endcase
         end
      end else if (com[1]) begin
         if (mode == MODE_FAST) begin
            if (step && (tcnt == MAX)) oc_nxt = ~com[0];
            else if (match)            oc_nxt = com[0];
         end else if (match) begin
            oc_nxt = dir ? ~com[0] : com[0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tcnt    <= ZERO;
         ocr     <= ZERO;
         ocr_act <= ZERO;
         tov     <= 1'b0;
         ocf     <= 1'b0;
         oc_reg  <= OC0_INIT;
         dir     <= 1'b0;
         skip    <= 1'b0;
      end else begin
         tcnt    <= tcnt_nxt;
         ocr_act <= ocr_act_nxt;
         oc_reg  <= oc_nxt;
         dir     <= dir_nxt;
         if (ocr_wr) ocr <= ocr_din;
         if (tcnt_wr)   skip <= 1'b1;
         else if (step) skip <= 1'b0;
         tov <= tov_set | (tov & ~tov_clr);
         ocf <= match | (ocf & ~ocf_clr);
      end
   end
endmodule

// File: tb/tb_timer0_count_unit.sv
// tb/tb_timer0_count_unit.sv - self-checking bench for timer0_count_unit
// Reference model tracks Phase-Correct PWM as a position within the 510-tick period.
module tb_timer0_count_unit;
   localparam bit OC0_INIT = 1'b0;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b0;
   logic [1:0] wgm = 2'b00;
   logic [1:0] com = 2'b00;
   logic       tcnt_wr = 1'b0;
   logic [7:0] tcnt_din = 8'h00;
   logic       ocr_wr = 1'b0;
   logic [7:0] ocr_din = 8'h00;
   logic       tov_clr = 1'b0;
   logic       ocf_clr = 1'b0;
`ifdef TIMER0_FOC_EN
   logic       foc = 1'b0;
`endif
   logic [7:0] tcnt;
   logic [7:0] ocr;
   logic       tov;
   logic       ocf;
   logic       oc0;

   int vectors = 0;
   int miscompares = 0;

   int m_tcnt, m_pos, m_buf, m_act;
   bit m_tov, m_ocf, m_oc, m_skip;

   timer0_count_unit #(.WIDTH(8), .OC0_INIT(OC0_INIT)) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .wgm(wgm), .com(com),
      .tcnt_wr(tcnt_wr), .tcnt_din(tcnt_din), .ocr_wr(ocr_wr), .ocr_din(ocr_din),
      .tov_clr(tov_clr), .ocf_clr(ocf_clr),
`ifdef TIMER0_FOC_EN
      .foc(foc),
`endif
      .tcnt(tcnt), .ocr(ocr), .tov(tov), .ocf(ocf), .oc0(oc0)
   );

   always #5 clk = ~clk;

   task automatic model_step();
      int t, n_t, n_pos, n_act;
      bit stp, hit, fhit, tovs, n_oc, nonpwm;
      if (!rst_n) begin
         m_tcnt = 0; m_pos = 0; m_buf = 0; m_act = 0;
         m_tov = 0; m_ocf = 0; m_oc = OC0_INIT; m_skip = 0;
         return;
      end
      t      = m_tcnt;
      nonpwm = (wgm == 2'b00) || (wgm == 2'b10);
      stp    = tick && !tcnt_wr;
      hit    = stp && !m_skip && (t == m_act);
      fhit   = 1'b0;
`ifdef TIMER0_FOC_EN
      fhit   = foc && nonpwm;
`endif
      n_t = t; n_pos = m_pos; n_act = m_act; tovs = 0; n_oc = m_oc;
      if (tcnt_wr) n_t = int'(tcnt_din);
      else if (stp) begin
         case (wgm)
            2'b00: begin n_t = (t + 1) % 256; tovs = (t == 255); end
            2'b10: begin n_t = hit ? 0 : (t + 1) % 256; tovs = (t == 255); end
            2'b11: begin
               n_t = (t + 1) % 256; tovs = (t == 255);
               if (tovs) n_act = m_buf;
            end
            default: begin
               n_pos = (m_pos + 1) % 510;
               n_t   = (n_pos <= 255) ? n_pos : 510 - n_pos;
               if (n_t == 255) n_act = m_buf;
               tovs  = (n_pos == 0);
            end
         endcase
      end
      if (nonpwm) begin
         if (hit || fhit) begin
            if (com == 2'b01) n_oc = !m_oc;
            else if (com == 2'b10) n_oc = 0;
            else if (com == 2'b11) n_oc = 1;
         end
      end else if (com >= 2'b10) begin
         if (wgm == 2'b11) begin
            if (stp && t == 255) n_oc = (com == 2'b10);
            else if (hit)        n_oc = (com == 2'b11);
         end else if (hit) begin
            n_oc = (m_pos < 255) ? (com == 2'b11) : (com == 2'b10);
         end
      end
      if (ocr_wr && nonpwm) n_act = int'(ocr_din);
      m_ocf = hit || (m_ocf && !ocf_clr);
      m_tov = tovs || (m_tov && !tov_clr);
      if (ocr_wr) m_buf = int'(ocr_din);
      if (tcnt_wr) m_skip = 1; else if (stp) m_skip = 0;
      m_tcnt = n_t; m_act = n_act; m_oc = n_oc;
      m_pos  = (wgm == 2'b01 && !tcnt_wr) ? n_pos : n_t;
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      tcnt_wr = 0; ocr_wr = 0; tov_clr = 0; ocf_clr = 0;
`ifdef TIMER0_FOC_EN
      foc = 0;
`endif
   endtask

   function automatic logic [18:0] dut_vec();
      return {tcnt, ocr, tov, ocf, oc0};
   endfunction

   function automatic logic [18:0] exp_vec();
      logic [7:0] et, eb;
      bit conn;
      et   = m_tcnt[7:0];
      eb   = m_buf[7:0];
      conn = com[1] || (com == 2'b01 && (wgm == 2'b00 || wgm == 2'b10));
      return {et, eb, m_tov, m_ocf, m_oc & conn};
   endfunction

   task automatic do_reset();
      tick = 0; rst_n = 0;
      cycle();
      rst_n = 1;
   endtask

   task automatic test_reset();
      tick = 1; wgm = 2'b11; com = 2'b11; rst_n = 0;
      cycle();
      vectors++;
      if (tcnt !== 8'h00) begin miscompares++; $display("FAIL reset_tcnt got %h want 00", tcnt); end
      vectors++;
      if (ocr !== 8'h00) begin miscompares++; $display("FAIL reset_ocr got %h want 00", ocr); end
      vectors++;
      if ({tov, ocf} !== 2'b00) begin miscompares++; $display("FAIL reset_flags got %b want 00", {tov, ocf}); end
      vectors++;
      if (oc0 !== OC0_INIT) begin miscompares++; $display("FAIL reset_oc0 got %b want %b", oc0, OC0_INIT); end
      rst_n = 1;
   endtask

   task automatic test_normal();
      do_reset();
      wgm = 2'b00; com = 2'b01; tick = 1;
      for (int i = 0; i < 258; i++) begin
         cycle();
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++; $display("FAIL normal cyc %0d got %h want %h", i, dut_vec(), exp_vec());
         end
         if (i == 255) begin
            vectors++;
            if ({tcnt, tov, ocf} !== {8'h00, 1'b1, 1'b1}) begin
               miscompares++; $display("FAIL normal_wrap got %h/%b/%b want 00/1/1", tcnt, tov, ocf);
            end
         end
      end
   endtask

   task automatic test_ctc();
      int toggles;
      logic prev;
      do_reset();
      wgm = 2'b10; com = 2'b01; ocr_din = 8'h09; ocr_wr = 1;
      cycle();
      tick = 1; toggles = 0; prev = oc0;
      for (int i = 0; i < 60; i++) begin
         cycle();
         if (oc0 !== prev) toggles++;
         prev = oc0;
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++; $display("FAIL ctc cyc %0d got %h want %h", i, dut_vec(), exp_vec());
         end
      end
      vectors++;
      if (toggles != 6 || tov !== 1'b0) begin
         miscompares++; $display("FAIL ctc_period toggles %0d tov %b want 6 0", toggles, tov);
      end
   endtask

   task automatic test_fast_pwm();
      int hi1, hi2;
      do_reset();
      wgm = 2'b11; com = 2'b10; ocr_din = 8'h40; ocr_wr = 1;
      cycle();
      tick = 1; hi1 = 0; hi2 = 0;
      for (int i = 0; i < 768; i++) begin
         if (i == 400) begin ocr_din = 8'h80; ocr_wr = 1; end
         cycle();
         if (i >= 256 && i < 512 && oc0) hi1++;
         if (i >= 512 && oc0) hi2++;
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++; $display("FAIL fast cyc %0d got %h want %h", i, dut_vec(), exp_vec());
         end
      end
      vectors++;
      if (hi1 != 65 || hi2 != 129) begin
         miscompares++; $display("FAIL fast_duty high %0d/%0d want 65/129", hi1, hi2);
      end
   endtask

   task automatic test_pc_pwm();
      int lo, first_tov, second_tov;
      do_reset();
      wgm = 2'b01; com = 2'b10; ocr_din = 8'h80; ocr_wr = 1;
      cycle();
      tick = 1; lo = 0; first_tov = -1; second_tov = -1;
      for (int i = 0; i < 1100; i++) begin
         tov_clr = 1;
         cycle();
         if (i >= 510 && i < 1020 && !oc0) lo++;
         if (tov) begin
            if (first_tov < 0) first_tov = i;
            else if (second_tov < 0) second_tov = i;
         end
         vectors++;
         if (dut_vec() !== exp_vec()) begin
            miscompares++; $display("FAIL pcpwm cyc %0d got %h want %h", i, dut_vec(), exp_vec());
         end
      end
      vectors++;
      if (lo != 254 || first_tov != 509 || second_tov - first_tov != 510) begin
         miscompares++;
         $display("FAIL pcpwm_period low %0d tov at %0d,%0d want 254 509,1019", lo, first_tov, second_tov);
      end
   endtask

   task automatic test_flags_and_write();
      do_reset();
      wgm = 2'b00; com = 2'b00;
      tcnt_din = 8'hFE; tcnt_wr = 1;
      cycle();
      tick = 1;
      cycle();
      tov_clr = 1;
      cycle();
      vectors++;
      if ({tcnt, tov} !== {8'h00, 1'b1}) begin
         miscompares++; $display("FAIL tov_set_beats_clr got %h/%b want 00/1", tcnt, tov);
      end
      ocr_din = 8'h05; ocr_wr = 1; tick = 0; tov_clr = 1; ocf_clr = 1;
      cycle();
      tick = 1; tcnt_din = 8'h05; tcnt_wr = 1;
      cycle();
      vectors++;
      if (tcnt !== 8'h05) begin miscompares++; $display("FAIL wr_beats_tick got %h want 05", tcnt); end
      cycle();
      vectors++;
      if ({tcnt, ocf} !== {8'h06, 1'b0}) begin
         miscompares++; $display("FAIL match_suppress got %h/%b want 06/0", tcnt, ocf);
      end
      vectors++;
      if (dut_vec() !== exp_vec()) begin
         miscompares++; $display("FAIL flags_model got %h want %h", dut_vec(), exp_vec());
      end
   endtask

   task automatic test_reset_mid_pwm();
      do_reset();
      wgm = 2'b11; com = 2'b11; ocr_din = 8'h33; ocr_wr = 1; tick = 1;
      for (int i = 0; i < 300; i++) cycle();
      rst_n = 0;
      cycle();
      rst_n = 1;
      vectors++;
      if (dut_vec() !== {8'h00, 8'h00, 1'b0, 1'b0, OC0_INIT}) begin
         miscompares++; $display("FAIL reset_mid got %h want %h", dut_vec(), {16'h0, 2'b00, OC0_INIT});
      end
   endtask

`ifdef TIMER0_FOC_EN
   task automatic test_foc();
      do_reset();
      wgm = 2'b10; com = 2'b01; ocr_din = 8'h50; ocr_wr = 1;
      cycle();
      foc = 1;
      cycle();
      vectors++;
      if ({tcnt, ocf, oc0} !== {8'h00, 1'b0, ~OC0_INIT}) begin
         miscompares++; $display("FAIL foc got %h/%b/%b want 00/0/%b", tcnt, ocf, oc0, ~OC0_INIT);
      end
   endtask
`endif

   task automatic test_random();
      for (int s = 0; s < 8; s++) begin
         do_reset();
         wgm = 2'($urandom_range(0, 3));
         com = 2'($urandom_range(0, 3));
         for (int i = 0; i < 400; i++) begin
            tick     = 1'($urandom_range(0, 1));
            ocr_wr   = ($urandom_range(0, 15) == 0);
            ocr_din  = 8'($urandom);
            tcnt_wr  = (wgm != 2'b01) && ($urandom_range(0, 31) == 0);
            tcnt_din = 8'($urandom);
            tov_clr  = ($urandom_range(0, 7) == 0);
            ocf_clr  = ($urandom_range(0, 7) == 0);
`ifdef TIMER0_FOC_EN
            foc      = ($urandom_range(0, 15) == 0);
`endif
            if ($urandom_range(0, 63) == 0) com = 2'($urandom_range(0, 3));
            if (wgm != 2'b01 && $urandom_range(0, 63) == 0) begin
               case ($urandom_range(0, 2))
                  0:       wgm = 2'b00;
                  1:       wgm = 2'b10;
                  default: wgm = 2'b11;
               endcase
            end
            cycle();
            vectors++;
            if (dut_vec() !== exp_vec()) begin
               miscompares++;
               $display("FAIL random seg %0d cyc %0d got %h want %h", s, i, dut_vec(), exp_vec());
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_ctc();
      test_fast_pwm();
      test_pc_pwm();
      test_flags_and_write();
      test_reset_mid_pwm();
`ifdef TIMER0_FOC_EN
      test_foc();
`endif
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
